// File: rtl/start_screen_pkg.sv
// start_screen_pkg: shared constants and types for the start-screen
// pixel fetch and palette stages.
package start_screen_pkg;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam logic [3:0] BG_INDEX = 4'd0;

  typedef logic [3:0] idx_t;

  typedef struct packed {
    logic inimg;
    logic blank;
    logic hs;
    logic vs;
    logic mask;
  } pix_pipe_t;

  localparam pix_pipe_t PIPE_IDLE = '{
    inimg: 1'b0,
    blank: 1'b0,
    hs:    1'b1,
    vs:    1'b1,
    mask:  1'b0
  };

endpackage

// File: rtl/start_screen_blink_timer.sv
// start_screen_blink_timer: counts frames and flips the blink phase
// every BLINK_FRAMES frames. Only built when BLINK_EN is defined.
`ifdef BLINK_EN
module start_screen_blink_timer
  import start_screen_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  output logic hidden
);

  localparam int CW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      hidden <= 1'b0;
    end else if (frame_tick) begin
      if (cnt == CW'(BLINK_FRAMES - 1)) begin
        cnt    <= '0;
        hidden <= ~hidden;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
`endif

// File: rtl/start_screen_pixel_fetch.sv
// start_screen_pixel_fetch: raster coords -> image ROM reads, index and
// syncs aligned 3 clk later. Blink rectangle is built with BLINK_EN.
module start_screen_pixel_fetch
  import start_screen_pkg::*;
#(
  parameter int IMG_W = start_screen_pkg::IMG_W,
  parameter int IMG_H = start_screen_pkg::IMG_H,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W = 17,
  parameter logic [3:0] BG_INDEX = start_screen_pkg::BG_INDEX
`ifdef BLINK_EN
  ,
  parameter int BLINK_FRAMES = 30,
  parameter int BLINK_X0 = 240,
  parameter int BLINK_X1 = 400,
  parameter int BLINK_Y0 = 360,
  parameter int BLINK_Y1 = 392
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        drawX,
  input  logic [9:0]        drawY,
  input  logic              blank,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [3:0]        rom_q,
  output logic [3:0]        index,
  output logic              pix_valid,
  output logic              hs_out,
  output logic              vs_out
);

  localparam int XLAST = (IMG_W << SCALE_SHIFT) - 1;
  localparam logic [9:0] SUB =
    10'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW_MAX =
    ADDR_W'(IMG_W * (IMG_H - 1));

  logic [9:0]        sx;
  logic [9:0]        sy;
  logic              inimg;
  logic              mask;
  logic              vs_prev;
  logic              vs_fall;
  logic              line_end;
  logic [ADDR_W-1:0] row_base;
  pix_pipe_t         p1;
  pix_pipe_t         p2;

  assign sx = drawX >> SCALE_SHIFT;
  assign sy = drawY >> SCALE_SHIFT;

  assign inimg = blank
               & (sx < 10'(IMG_W))
               & (sy < 10'(IMG_H));

  assign vs_fall = vs_prev & ~vs_in;

  // Last screen pixel of the last screen line of a source row.
  assign line_end = blank
                  & (drawX == 10'(XLAST))
                  & ((drawY & SUB) == SUB)
                  & (sy < 10'(IMG_H));

`ifdef BLINK_EN
  logic hidden;

  start_screen_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(vs_fall),
    .hidden    (hidden)
  );

  assign mask = hidden
              & (drawX >= 10'(BLINK_X0))
              & (drawX <= 10'(BLINK_X1))
              & (drawY >= 10'(BLINK_Y0))
              & (drawY <= 10'(BLINK_Y1));
`else
  assign mask = 1'b0;
`endif

  // Row base saturates on the last row so a lost vsync stays in-ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev  <= 1'b1;
      row_base <= '0;
    end else begin
      vs_prev <= vs_in;
      if (vs_fall) begin
        row_base <= '0;
      end else if (line_end && (row_base < ROW_MAX)) begin
        row_base <= row_base + ROW_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      rom_rd   <= 1'b0;
      p1       <= PIPE_IDLE;
    end else begin
      rom_rd <= inimg;
      if (inimg) begin
        rom_addr <= row_base + ADDR_W'(sx);
      end
      p1 <= '{
        inimg: inimg,
        blank: blank,
        hs:    hs_in,
        vs:    vs_in,
        mask:  mask
      };
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2 <= PIPE_IDLE;
    end else begin
      p2 <= p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index     <= BG_INDEX;
      pix_valid <= 1'b0;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
    end else begin
      index     <= (p2.inimg & ~p2.mask) ? rom_q : BG_INDEX;
      pix_valid <= p2.blank;
      hs_out    <= p2.hs;
      vs_out    <= p2.vs;
    end
  end

endmodule

// File: tb/tb_start_screen_pixel_fetch.sv
// tb_start_screen_pixel_fetch: random ROM image and random blank drops
// on a reduced raster, scored against an arithmetic reference model.
module tb_start_screen_pixel_fetch;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int AW = 11;
  localparam logic [3:0] BG = 4'd5;
  localparam int HT = 100;
  localparam int HA = 88;
  localparam int VT = 70;
  localparam int VA = 64;
  localparam int NF = 6;
  localparam int BF = 2;
  localparam int BX0 = 20;
  localparam int BX1 = 40;
  localparam int BY0 = 10;
  localparam int BY1 = 20;

  logic          clk;
  logic          rst_n;
  logic [9:0]    drawX;
  logic [9:0]    drawY;
  logic          blank;
  logic          hs_in;
  logic          vs_in;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [3:0]    rom_q;
  logic [3:0]    index;
  logic          pix_valid;
  logic          hs_out;
  logic          vs_out;

  start_screen_pixel_fetch #(
    .IMG_W(W),
    .IMG_H(H),
    .SCALE_SHIFT(1),
    .ADDR_W(AW),
    .BG_INDEX(BG)
`ifdef BLINK_EN
    ,
    .BLINK_FRAMES(BF),
    .BLINK_X0(BX0),
    .BLINK_X1(BX1),
    .BLINK_Y0(BY0),
    .BLINK_Y1(BY1)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .drawX(drawX),
    .drawY(drawY),
    .blank(blank),
    .hs_in(hs_in),
    .vs_in(vs_in),
    .rom_addr(rom_addr),
    .rom_rd(rom_rd),
    .rom_q(rom_q),
    .index(index),
    .pix_valid(pix_valid),
    .hs_out(hs_out),
    .vs_out(vs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rom [W*H];

  always @(posedge clk) begin
    if (int'(rom_addr) < W * H) rom_q <= rom[rom_addr];
    else rom_q <= 4'd0;
  end

  typedef struct {
    int x;
    int y;
    bit rd;
    int addr;
    bit exact;
  } rom_exp_t;

  typedef struct {
    int x;
    int y;
    logic [3:0] idx;
    bit chk;
    bit pv;
    bit hs;
    bit vs;
  } pix_exp_t;

  rom_exp_t q_rom[$];
  pix_exp_t q_pix[$];

  int total = 0;
  int bad = 0;
  bit mon_en = 0;

  int last_addr;
  bit addr_known;
  int falls;
  bit prev_vs;

  task automatic report(input bit ok, input string nm,
                        input int act, input int exp,
                        input int x, input int y);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s at (%0d,%0d): got %0d want %0d",
               nm, x, y, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q_rom.size() > 1) begin
        rom_exp_t r;
        r = q_rom.pop_front();
        report(rom_rd == r.rd, "rom_rd",
               int'(rom_rd), int'(r.rd), r.x, r.y);
        if (r.exact)
          report(int'(rom_addr) == r.addr, "rom_addr",
                 int'(rom_addr), r.addr, r.x, r.y);
        else
          report(int'(rom_addr) <= W * H - 1, "rom_addr_bound",
                 int'(rom_addr), W * H - 1, r.x, r.y);
      end
      if (q_pix.size() > 3) begin
        pix_exp_t p;
        p = q_pix.pop_front();
        if (p.chk)
          report(index == p.idx, "index",
                 int'(index), int'(p.idx), p.x, p.y);
        report(pix_valid == p.pv, "pix_valid",
               int'(pix_valid), int'(p.pv), p.x, p.y);
        report(hs_out == p.hs, "hs_out",
               int'(hs_out), int'(p.hs), p.x, p.y);
        report(vs_out == p.vs, "vs_out",
               int'(vs_out), int'(p.vs), p.x, p.y);
      end
    end
  end

  task automatic step(input int x, input int y, input bit bl,
                      input bit hs, input bit vs,
                      input bit push, input bit synced);
    rom_exp_t r;
    pix_exp_t p;
    int sx;
    int sy;
    bit in;
    bit msk;
    @(posedge clk);
    #1;
    drawX = 10'(x);
    drawY = 10'(y);
    blank = bl;
    hs_in = hs;
    vs_in = vs;
    if (push) begin
      sx = x / 2;
      sy = y / 2;
      in = bl && sx < W && sy < H;
      msk = 1'b0;
`ifdef BLINK_EN
      msk = ((falls / BF) % 2 == 1) &&
            x >= BX0 && x <= BX1 && y >= BY0 && y <= BY1;
`endif
      if (in) begin
        last_addr = sy * W + sx;
        addr_known = synced;
      end
      r.x = x;
      r.y = y;
      r.rd = in;
      r.addr = last_addr;
      r.exact = addr_known;
      q_rom.push_back(r);
      p.x = x;
      p.y = y;
      p.idx = (in && !msk) ? rom[sy * W + sx] : BG;
      p.chk = synced || !in || msk;
      p.pv = bl;
      p.hs = hs;
      p.vs = vs;
      q_pix.push_back(p);
      if (prev_vs && !vs) falls++;
      prev_vs = vs;
    end
  endtask

  bit vs_ok;
  bit synced;
  bit prev_frame_vs;
  bit bl;
  bit hs;
  bit vs;

  initial begin
    for (int i = 0; i < W * H; i++) rom[i] = 4'($urandom);
    rst_n = 1'b0;
    drawX = '0;
    drawY = '0;
    blank = 1'b0;
    hs_in = 1'b1;
    vs_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Partial line with syncs asserted, then an async reset mid-line.
    for (int x = 0; x < 20; x++)
      step(x, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    report(index == BG, "rst_index", int'(index), int'(BG), 0, 0);
    report(pix_valid == 1'b0, "rst_pix_valid",
           int'(pix_valid), 0, 0, 0);
    report(hs_out == 1'b1, "rst_hs_out", int'(hs_out), 1, 0, 0);
    report(vs_out == 1'b1, "rst_vs_out", int'(vs_out), 1, 0, 0);
    report(rom_rd == 1'b0, "rst_rom_rd", int'(rom_rd), 0, 0, 0);
    report(rom_addr == '0, "rst_rom_addr", int'(rom_addr), 0, 0, 0);
    drawX = '0;
    drawY = '0;
    blank = 1'b0;
    hs_in = 1'b1;
    vs_in = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    last_addr = 0;
    addr_known = 1'b1;
    falls = 0;
    prev_vs = 1'b1;
    prev_frame_vs = 1'b1;
    mon_en = 1'b1;

    // Frames 2 and 3 lose their vsync pulse.
    for (int f = 0; f < NF; f++) begin
      vs_ok = (f != 2) && (f != 3);
      synced = (f == 0) || prev_frame_vs;
      for (int y = 0; y < VT; y++) begin
        for (int x = 0; x < HT; x++) begin
          bl = (x < HA) && (y < VA);
          if (bl && x != 2 * W - 1 && $urandom_range(15) == 0)
            bl = 1'b0;
          hs = !(x >= 92 && x <= 95);
          vs = !(vs_ok && y >= 66 && y <= 67);
          step(x, y, bl, hs, vs, 1'b1, synced);
        end
      end
      prev_frame_vs = vs_ok;
    end

    for (int i = 0; i < 4; i++)
      step(0, VA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
